// File: rtl/raw2axis_pkg.sv
// Shared types for the raw pixel to AXI4-Stream video bridge.
// FIFO entries are {user, last, data}.
package raw2axis_pkg;

    typedef enum logic [1:0] {
        WAIT_SOF = 2'd0,
        STREAM   = 2'd1,
        DROP     = 2'd2
    } state_t;

    function automatic int user_bit(input int dw);
        return dw + 1;
    endfunction

    function automatic int last_bit(input int dw);
        return dw;
    endfunction

endpackage

// File: rtl/raw2axis_video_if.sv
// AXI4-Stream video channel: tuser marks start of frame,
// tlast marks end of line.
interface raw2axis_video_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] tdata;
    logic                  tvalid;
    logic                  tready;
    logic                  tuser;
    logic                  tlast;

    modport master (
        output tdata, tvalid, tuser, tlast,
        input  tready
    );

    modport slave (
        input  tdata, tvalid, tuser, tlast,
        output tready
    );
endinterface

// File: rtl/pix_fifo.sv
// First-word-fall-through FIFO with a registered output stage.
// Capacity counts the output register, so total occupancy never exceeds 2^ADDR_WIDTH.
module pix_fifo #(
    parameter int ADDR_WIDTH = 11,
    parameter int WIDTH      = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    output logic             full,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             empty
);
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] CNT_ONE = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH:0] CNT_FULL = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE = ADDR_WIDTH'(1);

    logic [WIDTH-1:0]      mem [DEPTH];
    logic [ADDR_WIDTH-1:0] wptr;
    logic [ADDR_WIDTH-1:0] rptr;
    logic [ADDR_WIDTH:0]   mem_cnt;
    logic [ADDR_WIDTH:0]   count;
    logic                  out_valid;
    logic                  do_wr;
    logic                  load;

    // Full is judged before any read this cycle, keeping the write path short.
    assign count = mem_cnt + {{ADDR_WIDTH{1'b0}}, out_valid};
    assign full  = (count == CNT_FULL);
    assign do_wr = wr_en && !full;
    assign load  = (mem_cnt != '0) && (!out_valid || rd_en);
    assign empty = !out_valid;

    always_ff @(posedge clk) begin
        if (do_wr) mem[wptr] <= wr_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr      <= '0;
            rptr      <= '0;
            mem_cnt   <= '0;
            out_valid <= 1'b0;
            rd_data   <= '0;
        end else begin
            if (do_wr) wptr <= wptr + PTR_ONE;
            if (load) begin
                rptr      <= rptr + PTR_ONE;
                rd_data   <= mem[rptr];
                out_valid <= 1'b1;
            end else if (rd_en) begin
                out_valid <= 1'b0;
            end
            unique case ({do_wr, load})
                2'b10:   mem_cnt <= mem_cnt + CNT_ONE;
                2'b01:   mem_cnt <= mem_cnt - CNT_ONE;
                default: ;
            endcase
        end
    end
endmodule

// File: rtl/raw2axis_video.sv
// Free-running raw pixel stream to AXI4-Stream video, with frame tagging
// and clean frame drop on FIFO overflow.
module raw2axis_video
    import raw2axis_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480,
    parameter int ADDR_WIDTH = 11
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] raw_data,
    input  logic                  raw_valid,
    input  logic                  raw_sof,
    raw2axis_video_if.master      m_axis,
    output logic                  overflow,
    output logic                  frame_err,
    output logic [15:0]           frame_cnt
);
    localparam int W        = DATA_WIDTH + 2;
    localparam int USER_BIT = user_bit(DATA_WIDTH);
    localparam int LAST_BIT = last_bit(DATA_WIDTH);
    localparam int COL_W    = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
    localparam int ROW_W    = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
    localparam logic [COL_W-1:0] COL_MAX = COL_W'(IMG_WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(IMG_HEIGHT - 1);

    state_t           state;
    logic [COL_W-1:0] col;
    logic [COL_W-1:0] col_eff;
    logic [ROW_W-1:0] row;
    logic [ROW_W-1:0] row_eff;
    logic             wr_en;
    logic             wr_last;
    logic             frame_end;
    logic             full;
    logic             empty;
    logic [W-1:0]     wr_data;
    logic [W-1:0]     rd_data;

    // A sof pixel always restarts position, whatever state we are in.
    assign col_eff   = raw_sof ? '0 : col;
    assign row_eff   = raw_sof ? '0 : row;
    assign wr_last   = (col_eff == COL_MAX);
    assign frame_end = wr_last && (row_eff == ROW_MAX);
    assign wr_en     = raw_valid && (raw_sof || state == STREAM);
    assign wr_data   = {raw_sof, wr_last, raw_data};

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= WAIT_SOF;
            col       <= '0;
            row       <= '0;
            overflow  <= 1'b0;
            frame_err <= 1'b0;
            frame_cnt <= '0;
        end else if (wr_en) begin
            if (state == STREAM && raw_sof) frame_err <= 1'b1;
            if (full) begin
                overflow <= 1'b1;
                state    <= DROP;
            end else if (frame_end) begin
                frame_cnt <= frame_cnt + 16'd1;
                state     <= WAIT_SOF;
                col       <= '0;
                row       <= '0;
            end else if (wr_last) begin
                state <= STREAM;
                col   <= '0;
                row   <= row_eff + ROW_W'(1);
            end else begin
                state <= STREAM;
                col   <= col_eff + COL_W'(1);
                row   <= row_eff;
            end
        end
    end

    pix_fifo #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .WIDTH      (W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_data (wr_data),
        .full    (full),
        .rd_en   (m_axis.tready),
        .rd_data (rd_data),
        .empty   (empty)
    );

    assign m_axis.tvalid = !empty;
    assign m_axis.tdata  = rd_data[DATA_WIDTH-1:0];
    assign m_axis.tuser  = rd_data[USER_BIT];
    assign m_axis.tlast  = rd_data[LAST_BIT];
endmodule

// File: tb/tb_raw2axis_video.sv
// Directed bench for raw2axis_video: 4x2 frames through a 4-entry FIFO,
// beats checked against a scoreboard queue.
module tb_raw2axis_video;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] raw_data = '0;
    logic          raw_valid = 1'b0;
    logic          raw_sof = 1'b0;
    logic          overflow;
    logic          frame_err;
    logic [15:0]   frame_cnt;

    raw2axis_video_if #(.DATA_WIDTH(DW)) ax ();

    raw2axis_video #(
        .DATA_WIDTH (DW),
        .IMG_WIDTH  (4),
        .IMG_HEIGHT (2),
        .ADDR_WIDTH (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .raw_data  (raw_data),
        .raw_valid (raw_valid),
        .raw_sof   (raw_sof),
        .m_axis    (ax),
        .overflow  (overflow),
        .frame_err (frame_err),
        .frame_cnt (frame_cnt)
    );

    always #5 clk = ~clk;

    logic [DW+1:0] sb [$];
    int            total = 0;
    int            bad = 0;
    logic          toggle_rdy = 1'b0;
    logic [3:0]    rdy_pat = 4'b1001;
    int            cyc = 0;
    logic          stall_q = 1'b0;
    logic [DW+1:0] held = '0;
    logic [DW+1:0] beat;
    logic [DW+1:0] expv;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (toggle_rdy) begin
            ax.tready = rdy_pat[cyc % 4];
            cyc++;
        end
    endtask

    task automatic pix(input logic [DW-1:0] d, input logic sof,
                       input bit wr, input logic u, input logic l);
        raw_valid = 1'b1;
        raw_sof   = sof;
        raw_data  = d;
        if (wr) sb.push_back({u, l, d});
        tick();
        raw_valid = 1'b0;
        raw_sof   = 1'b0;
    endtask

    task automatic send_frame(input logic [DW-1:0] base, input int gap);
        for (int i = 0; i < 8; i++) begin
            pix(base + DW'(i), i == 0, 1'b1, i == 0, (i % 4) == 3);
            repeat (gap) tick();
        end
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 60 && sb.size() != 0; i++) tick();
        repeat (3) tick();
        check(tag, sb.size(), 0);
    endtask

    // Output monitor: scoreboard pops and stall-stability on the falling edge.
    always @(negedge clk) begin
        beat = {ax.tuser, ax.tlast, ax.tdata};
        if (rst) begin
            stall_q <= 1'b0;
        end else begin
            if (stall_q) begin
                check("stall_valid", ax.tvalid, 1);
                check("stall_hold", beat, held);
            end
            if (ax.tvalid && ax.tready) begin
                check("beat_expected", sb.size() != 0, 1);
                if (sb.size() != 0) begin
                    expv = sb.pop_front();
                    check("beat", beat, expv);
                end
            end
            stall_q <= ax.tvalid && !ax.tready;
            held    <= beat;
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

    initial begin
        ax.tready = 1'b1;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        check("rst_tvalid", ax.tvalid, 0);
        check("rst_tuser", ax.tuser, 0);
        check("rst_tlast", ax.tlast, 0);
        check("rst_overflow", overflow, 0);
        check("rst_frame_err", frame_err, 0);
        check("rst_frame_cnt", frame_cnt, 0);

        // Basic frame, tready held high
        send_frame(8'h00, 0);
        drain("t1_drain");
        check("t1_frame_cnt", frame_cnt, 1);
        check("t1_overflow", overflow, 0);

        // Toggling tready, paced input
        toggle_rdy = 1'b1;
        send_frame(8'h10, 2);
        drain("t2_drain");
        toggle_rdy = 1'b0;
        ax.tready = 1'b1;
        check("t2_frame_cnt", frame_cnt, 2);
        check("t2_overflow", overflow, 0);

        // Garbage before sof
        for (int i = 0; i < 5; i++) pix(8'hAA, 1'b0, 1'b0, 1'b0, 1'b0);
        send_frame(8'h20, 0);
        drain("t3_drain");
        check("t3_frame_cnt", frame_cnt, 3);

        // Sof on 3rd pixel of row 1 truncates the frame
        for (int i = 0; i < 6; i++)
            pix(8'h30 + DW'(i), i == 0, 1'b1, i == 0, i == 3);
        check("t4_err_before", frame_err, 0);
        send_frame(8'h40, 0);
        check("t4_frame_err", frame_err, 1);
        drain("t4_drain");
        check("t4_frame_cnt", frame_cnt, 4);

        // Overflow with tready low
        ax.tready = 1'b0;
        tick();
        for (int i = 0; i < 8; i++) begin
            pix(8'h50 + DW'(i), i == 0, i < 4, i == 0, i == 3);
            if (i == 3) check("t5_ovf_before", overflow, 0);
            if (i == 4) check("t5_ovf_set", overflow, 1);
        end
        ax.tready = 1'b1;
        drain("t5_drain_partial");
        check("t5_frame_cnt_drop", frame_cnt, 4);
        send_frame(8'h60, 0);
        drain("t5_drain_next");
        check("t5_frame_cnt", frame_cnt, 5);
        check("t5_ovf_sticky", overflow, 1);
        check("t5_err_sticky", frame_err, 1);

        // Reset mid-frame with three entries buffered
        ax.tready = 1'b0;
        for (int i = 0; i < 3; i++)
            pix(8'h70 + DW'(i), i == 0, 1'b1, i == 0, 1'b0);
        check("t6_pre_valid", ax.tvalid, 1);
        rst = 1'b1;
        sb.delete();
        tick();
        rst = 1'b0;
        check("t6_tvalid", ax.tvalid, 0);
        check("t6_overflow", overflow, 0);
        check("t6_frame_err", frame_err, 0);
        check("t6_frame_cnt", frame_cnt, 0);
        ax.tready = 1'b1;
        for (int i = 3; i < 8; i++)
            pix(8'h70 + DW'(i), 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (4) tick();
        check("t6_idle_valid", ax.tvalid, 0);
        send_frame(8'h80, 0);
        drain("t6_drain");
        check("t6_frame_cnt_after", frame_cnt, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
